// File: rtl/hzdm_pkg.sv
// Shared types and constants for the hzdm hazard/issue controller.
package hzdm_pkg;

    localparam int NUM_REGS         = 32;
    localparam int REG_ADDR_W       = 5;
    localparam int MAX_INFLIGHT_DEF = 3;
    localparam int CNT_W_DEF        = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hzdm_state_t;

endpackage

// File: rtl/hzdm_sb.sv
// Per-register pending-write counters for x1..x31; x0 is never tracked.
import hzdm_pkg::*;

module hzdm_sb #(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_en,
    input  logic [REG_ADDR_W-1:0] inc_addr,
    input  logic                  dec_en,
    input  logic [REG_ADDR_W-1:0] dec_addr,
    output logic [NUM_REGS-1:0]   pend,
    output logic [NUM_REGS-1:0]   full,
    output logic                  all_zero,
    output logic                  underflow
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0]    cnt [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] uf;

    assign pend[0] = 1'b0;
    assign full[0] = 1'b0;
    assign uf[0]   = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic inc_r;
        logic dec_r;

        assign inc_r = inc_en && (inc_addr == REG_ADDR_W'(r));
        assign dec_r = dec_en && (dec_addr == REG_ADDR_W'(r));

        // Simultaneous issue and retire on the same register cancel out.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt[r] <= '0;
            end else if (inc_r && !dec_r) begin
                cnt[r] <= cnt[r] + 1'b1;
            end else if (dec_r && !inc_r && cnt[r] != '0) begin
                cnt[r] <= cnt[r] - 1'b1;
            end
        end

        assign pend[r] = (cnt[r] != '0);
        assign full[r] = (cnt[r] == MAX_C);
        assign uf[r]   = dec_r && !inc_r && (cnt[r] == '0);
    end

    assign all_zero  = ~|pend;
    assign underflow = |uf;

endmodule

// File: rtl/hzdm.sv
// Hazard and issue controller: gates the decode-to-execute handshake on
// scoreboard hazards, taken branches and a drain/quiesce sequence.
import hzdm_pkg::*;

module hzdm #(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dec_valid_i,
    output logic                  dec_ready_o,
    input  logic [REG_ADDR_W-1:0] dec_rs1_i,
    input  logic                  dec_rs1_used_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_i,
    input  logic                  dec_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] dec_rd_i,
    input  logic                  dec_rd_write_i,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    input  logic                  branch_i,
    output logic                  flush_o,
    input  logic                  wb_write_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic                  quiesce_i,
    output logic                  quiesced_o,
    output logic                  error_o,
    output logic [1:0]            dbg_state_o
);

    // Handshake: an instruction moves to exm in a cycle where issue_valid_o
    // and issue_ready_i are both high; dec_ready_o tells decm it may advance.
    // Both depend only on registered counters, never on this cycle's retire.

    hzdm_state_t         state;
    logic                quiesced_q;
    logic                error_q;
    logic [NUM_REGS-1:0] pend_vec;
    logic [NUM_REGS-1:0] full_vec;
    logic                all_zero;
    logic                underflow;
    logic                hazard;
    logic                block;
    logic                fire;
    logic                inc_en;

    hzdm_sb #(
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .CNT_W       (CNT_W)
    ) u_sb (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .inc_en   (inc_en),
        .inc_addr (dec_rd_i),
        .dec_en   (wb_write_i),
        .dec_addr (wb_addr_i),
        .pend     (pend_vec),
        .full     (full_vec),
        .all_zero (all_zero),
        .underflow(underflow)
    );

    assign hazard = (dec_rs1_used_i & pend_vec[dec_rs1_i])
                  | (dec_rs2_used_i & pend_vec[dec_rs2_i])
                  | (dec_rd_write_i & (dec_rd_i != '0) & full_vec[dec_rd_i]);

    assign block         = hazard | branch_i | (state != RUN);
    assign issue_valid_o = rst_i & dec_valid_i & ~block;
    assign dec_ready_o   = rst_i & issue_ready_i & ~block;
    assign fire          = issue_valid_o & issue_ready_i;
    assign inc_en        = fire & dec_rd_write_i;
    assign flush_o       = rst_i & branch_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= RUN;
            quiesced_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (underflow) begin
                error_q <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (quiesce_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Dropping the request wins over completing the drain.
                    if (!quiesce_i) begin
                        state <= RUN;
                    end else if (all_zero && !inc_en) begin
                        state      <= HALTED;
                        quiesced_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!quiesce_i) begin
                        state      <= RUN;
                        quiesced_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    quiesced_q <= 1'b0;
                end
            endcase
        end
    end

    assign quiesced_o  = rst_i & quiesced_q;
    assign error_o     = error_q;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_hzdm.sv
// Directed self-checking bench for hzdm: hazards, x0, saturation, branch,
// quiesce, underflow error and reset.
import hzdm_pkg::*;

module tb_hzdm;

    logic       clk;
    logic       rst;
    logic       dec_valid;
    logic       dec_ready;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
    logic [4:0] rd;
    logic       rd_write;
    logic       issue_valid;
    logic       issue_ready;
    logic       branch;
    logic       flush;
    logic       wb_write;
    logic [4:0] wb_addr;
    logic       quiesce;
    logic       quiesced;
    logic       error;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    hzdm dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dec_valid_i   (dec_valid),
        .dec_ready_o   (dec_ready),
        .dec_rs1_i     (rs1),
        .dec_rs1_used_i(rs1_used),
        .dec_rs2_i     (rs2),
        .dec_rs2_used_i(rs2_used),
        .dec_rd_i      (rd),
        .dec_rd_write_i(rd_write),
        .issue_valid_o (issue_valid),
        .issue_ready_i (issue_ready),
        .branch_i      (branch),
        .flush_o       (flush),
        .wb_write_i    (wb_write),
        .wb_addr_i     (wb_addr),
        .quiesce_i     (quiesce),
        .quiesced_o    (quiesced),
        .error_o       (error),
        .dbg_state_o   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs then settle before checks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic [4:0] s1, input logic u1,
                           input logic [4:0] s2, input logic u2,
                           input logic [4:0] d, input logic w);
        dec_valid = v;
        rs1 = s1; rs1_used = u1;
        rs2 = s2; rs2_used = u2;
        rd  = d;  rd_write = w;
        #1;
    endtask

    task automatic set_wb(input logic w, input logic [4:0] a);
        wb_write = w;
        wb_addr  = a;
        #1;
    endtask

    initial begin
        rst = 1'b0; issue_ready = 1'b1; branch = 1'b1; quiesce = 1'b0;
        wb_write = 1'b0; wb_addr = '0;
        set_dec(1, 0, 0, 0, 0, 1, 1);
        tick(); tick();
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_dec_ready", dec_ready, 0);
        chk("rst_flush", flush, 0);
        chk("rst_quiesced", quiesced, 0);
        chk("rst_error", error, 0);
        chk("rst_state", dbg_state, RUN);
        chk("rst_pend", dut.pend_vec, 0);

        rst = 1'b1; branch = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        tick();

        // RAW: fire rd=5 at t0, consumer stalls t1..t3, retire at t3, issue at t4
        set_dec(1, 0, 0, 0, 0, 5, 1);
        chk("raw_t0_issue", issue_valid, 1);
        tick();
        set_dec(1, 5, 1, 0, 0, 0, 0);
        chk("raw_t1_issue", issue_valid, 0);
        chk("raw_t1_ready", dec_ready, 0);
        tick();
        chk("raw_t2_issue", issue_valid, 0);
        tick();
        set_wb(1, 5);
        chk("raw_t3_issue", issue_valid, 0);
        chk("raw_t3_ready", dec_ready, 0);
        tick();
        set_wb(0, 0);
        chk("raw_t4_issue", issue_valid, 1);
        chk("raw_t4_ready", dec_ready, 1);
        tick();

        // x0 destination and reads are ignored; unused rs2 does not stall
        set_dec(1, 0, 0, 0, 0, 0, 1);
        chk("x0_rd_issue", issue_valid, 1);
        tick();
        set_dec(1, 0, 1, 0, 0, 0, 0);
        chk("x0_rs1_issue", issue_valid, 1);
        chk("x0_pend_empty", dut.pend_vec, 0);
        tick();
        set_dec(1, 0, 0, 0, 0, 7, 1);
        tick();
        set_dec(1, 0, 0, 7, 0, 0, 0);
        chk("rs2_unused_issue", issue_valid, 1);
        chk("pend7_only", dut.pend_vec, 32'h0000_0080);
        set_dec(1, 0, 0, 7, 1, 0, 0);
        chk("rs2_used_stall", issue_valid, 0);
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 7);
        tick();
        set_wb(0, 0);
        chk("pend7_cleared", dut.pend_vec, 0);

        // Saturation on x9, then combined issue+retire leaves the count unchanged
        set_dec(1, 0, 0, 0, 0, 9, 1);
        for (int i = 0; i < 3; i++) begin
            chk("sat_issue", issue_valid, 1);
            tick();
        end
        chk("sat_full9", dut.full_vec[9], 1);
        chk("sat_4th_issue", issue_valid, 0);
        chk("sat_4th_ready", dec_ready, 0);
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 9);
        tick();
        set_dec(1, 0, 0, 0, 0, 9, 1);
        chk("combo_issue", issue_valid, 1);
        tick();
        set_wb(0, 0);
        chk("combo_not_full", dut.full_vec[9], 0);
        chk("combo_issue_again", issue_valid, 1);
        tick();
        set_dec(0, 0, 0, 0, 0, 0, 0);
        chk("combo_count_was_2", dut.full_vec[9], 1);
        set_wb(1, 9);
        tick(); tick(); tick();
        set_wb(0, 0);
        chk("sat_drained", dut.pend_vec, 0);
        chk("sat_no_error", error, 0);

        // Branch kills issue for one cycle without touching counters
        set_dec(1, 0, 0, 0, 0, 10, 1);
        branch = 1'b1;
        #1;
        chk("br_flush", flush, 1);
        chk("br_issue", issue_valid, 0);
        chk("br_ready", dec_ready, 0);
        tick();
        branch = 1'b0;
        #1;
        chk("br_pend_unchanged", dut.pend_vec, 0);
        chk("br_flush_off", flush, 0);
        chk("br_next_issue", issue_valid, 1);
        tick();
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 10);
        tick();
        set_wb(0, 0);

        // Quiesce with x3 and x4 in flight
        set_dec(1, 0, 0, 0, 0, 3, 1);
        tick();
        set_dec(1, 0, 0, 0, 0, 4, 1);
        tick();
        set_dec(0, 0, 0, 0, 0, 0, 0);
        quiesce = 1'b1;
        #1;
        chk("q_t0_state", dbg_state, RUN);
        tick();
        set_dec(1, 0, 0, 0, 0, 0, 0);
        set_wb(1, 3);
        chk("q_t1_state", dbg_state, DRAIN);
        chk("q_t1_issue", issue_valid, 0);
        chk("q_t1_ready", dec_ready, 0);
        tick();
        set_wb(1, 4);
        chk("q_t2_quiesced", quiesced, 0);
        tick();
        set_wb(0, 0);
        chk("q_t3_quiesced", quiesced, 0);
        chk("q_t3_pend", dut.pend_vec, 0);
        tick();
        chk("q_t4_quiesced", quiesced, 1);
        chk("q_t4_state", dbg_state, HALTED);
        chk("q_t4_issue", issue_valid, 0);
        tick();
        chk("q_t5_quiesced", quiesced, 1);
        tick();
        quiesce = 1'b0;
        #1;
        chk("q_t6_quiesced", quiesced, 1);
        tick();
        chk("q_t7_quiesced", quiesced, 0);
        chk("q_t7_state", dbg_state, RUN);
        chk("q_t7_issue", issue_valid, 1);
        set_dec(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Underflow sets sticky error; reset mid-drain clears everything
        set_wb(1, 12);
        tick();
        set_wb(0, 0);
        chk("err_set", error, 1);
        tick(); tick();
        chk("err_held", error, 1);
        set_dec(1, 0, 0, 0, 0, 15, 1);
        tick();
        set_dec(1, 0, 0, 0, 0, 0, 0);
        quiesce = 1'b1;
        tick();
        chk("err_drain_state", dbg_state, DRAIN);
        chk("err_drain_pend", dut.pend_vec, 32'h0000_8000);
        rst = 1'b0;
        #1;
        chk("rst2_issue", issue_valid, 0);
        chk("rst2_ready", dec_ready, 0);
        tick();
        quiesce = 1'b0;
        #1;
        chk("rst2_error", error, 0);
        chk("rst2_state", dbg_state, RUN);
        chk("rst2_pend", dut.pend_vec, 0);
        chk("rst2_quiesced", quiesced, 0);
        rst = 1'b1;
        set_dec(1, 15, 1, 0, 0, 0, 0);
        chk("rst2_issue_after", issue_valid, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hzdm.md
Name: hzdm

Overview:
Scoreboard-based hazard and issue controller for the five-stage pipeline. Sits on the decm→exm handshake and gates it:
- stalls decode while a source register has a write still in flight in exm/lsm/wbm;
- kills issue on a taken branch;
- provides a drain/quiesce sequence so irq/drq handling can start from an empty back-end.

Parameters:
MAX_INFLIGHT, 3, maximum pending writes tracked per register (stages exm, lsm, wbm).
CNT_W, 2, per-register counter width; must satisfy 2^CNT_W-1 >= MAX_INFLIGHT.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset.
dec_valid_i  in  1  decm has an instruction to issue.
dec_ready_o  out  1  decm may advance; low = hold instruction and re-read operands.
dec_rs1_i  in  5  source 1 address.
dec_rs1_used_i  in  1  source 1 is read.
dec_rs2_i  in  5  source 2 address.
dec_rs2_used_i  in  1  source 2 is read.
dec_rd_i  in  5  destination address.
dec_rd_write_i  in  1  instruction writes rd.
issue_valid_o  out  1  valid toward exm.
issue_ready_i  in  1  exm ready.
branch_i  in  1  taken branch from exm, single-cycle pulse.
flush_o  out  1  kill ifm/decm contents.
wb_write_i  in  1  wbm register write this cycle.
wb_addr_i  in  5  wbm write address.
quiesce_i  in  1  request back-end drain (level).
quiesced_o  out  1  no writes in flight, issue blocked.
error_o  out  1  sticky: retire on a register with zero pending count.

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_i=0 at clk_i edge): all counters 0, state RUN, error_o=0. While rst_i=0, issue_valid_o, dec_ready_o, flush_o and quiesced_o are forced to 0.
- Scoreboard: pend[1..31], each CNT_W bits. x0 is never pending; rd=0 and wb_addr=0 are ignored.
- hazard = (rs1_used & pend[rs1]!=0) | (rs2_used & pend[rs2]!=0) | (rd_write & rd!=0 & pend[rd]==MAX_INFLIGHT).
- block = hazard | branch_i | state!=RUN.
- issue_valid_o = dec_valid_i & ~block. dec_ready_o = issue_ready_i & ~block. Both are combinational and use registered counters only.
- fire = issue_valid_o & issue_ready_i.
- Counter update, per register r:
  - increment if fire & rd_write & rd==r;
  - decrement if wb_write & wb_addr==r;
  - both in the same cycle: unchanged.
- Retire visibility: a retire in cycle t clears the hazard from cycle t+1. There is no same-cycle bypass; regm writes at the t edge.
- Underflow: decrement at count 0 leaves the count at 0 and sets error_o until reset.
- Increment at MAX_INFLIGHT cannot occur, because the hazard term blocks it.
- flush_o = branch_i (combinational, same cycle). A branch never affects counters: the branching instruction and older ones are already issued and retire normally.
- FSM:
  - RUN: quiesce_i=1 → DRAIN.
  - DRAIN: issue blocked. If all pend==0 and no increment this cycle → HALTED. If quiesce_i=0 → RUN.
  - HALTED: quiesced_o=1, issue blocked. quiesce_i=0 → RUN next cycle.
- quiesced_o is registered (state==HALTED).
- Simultaneous events:
  - branch_i with quiesce_i: both take effect.
  - retire in DRAIN is counted normally.
- Reset mid-drain returns to RUN with empty scoreboard.

Decomposition:
- Shared package additions: hzdm_state_t enum {RUN, DRAIN, HALTED}; constants NUM_REGS=32, REG_ADDR_W=5.
- Natural sub-module: hzdm_sb, the 31-entry counter array. It takes inc/dec address+enable and exports pending and full bit-vectors plus an all_zero flag and an underflow pulse.
- The FSM and handshake gating live in hzdm.

Test Plan:
- RAW hazard:
  - Stimulus: issue rd=5 (fire at t0); next instruction rs1=5 used; wb_write=1, addr=5 at t3.
  - Response: issue_valid_o=0 and dec_ready_o=0 for t1..t3; issue_valid_o=1 at t4.
- x0 and unused sources:
  - Stimulus: issue rd=0, then rs1=0 used; separately rs2=7 with rs2_used=0 while pend[7]=1.
  - Response: no stall in either case; pend[0] stays 0.
- Saturation and simultaneous inc/dec:
  - Stimulus: three back-to-back writes to rd=9, then a fourth write to rd=9; then in one cycle, fire rd=9 while wb_addr=9 retires.
  - Response: pend[9]=3 and the fourth write stalls; the combined cycle leaves pend[9] unchanged.
- Branch kill:
  - Stimulus: dec_valid_i=1, issue_ready_i=1, branch_i=1 for one cycle.
  - Response: flush_o=1 and issue_valid_o=0 that cycle; counters unchanged; normal issue the next cycle.
- Quiesce:
  - Stimulus: two writes in flight (rd=3, rd=4), assert quiesce_i; retires at t+2 and t+3; deassert quiesce_i at t+6.
  - Response: no issue from the assert; quiesced_o=1 from t+4 (registered, the cycle after the last retire empties the scoreboard); RUN and quiesced_o=0 at t+7.
- Error and reset:
  - Stimulus: wb_write=1, addr=12 with pend[12]=0; then rst_i=0 mid-DRAIN.
  - Response: error_o=1 and held until reset; after reset all outputs 0, state RUN, all counters 0.
